// File: rtl/bus_fabric_pkg.sv
// Shared definitions for the maxicore32 bus fabric: FSM states, tag field
// position, default region tables and the saturating counter helper.
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERROR  = 2'd2
  } bus_state_t;

  // Tag field expressed in byte-address bits; the master drives a word address.
  localparam int TAG_HI     = 31;
  localparam int TAG_LO     = 24;
  localparam int WORD_SHIFT = 2;
  localparam int CNT_W      = 8;

  localparam logic [31:0] DEFAULT_TAGS    = 32'hfffe_0100;
  localparam logic [15:0] DEFAULT_WAITS   = 16'h0000;
  localparam logic [7:0]  DEFAULT_TIMEOUT = 8'd255;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/bus_fabric_region_match.sv
// Combinational priority match of an address tag against the region tag table;
// the lowest matching region index wins.
module bus_fabric_region_match
  import bus_fabric_pkg::*;
#(
  parameter int                       NUM_REGIONS = 4,
  parameter logic [8*NUM_REGIONS-1:0] REGION_TAGS = DEFAULT_TAGS,
  parameter int                       IDX_W       = 2
) (
  input  logic [7:0]       tag,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (REGION_TAGS[8*i +: 8] == tag) begin
        hit   = 1'b1;
        index = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Address decoder and bus-cycle sequencer between the maxicore32 master and its
// slave regions: chip selects, wait states / ack handshake, read mux, bus errors.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                       NUM_REGIONS  = 4,
  parameter logic [8*NUM_REGIONS-1:0] REGION_TAGS  = DEFAULT_TAGS,
  parameter logic [4*NUM_REGIONS-1:0] REGION_WAITS = DEFAULT_WAITS,
  parameter logic [NUM_REGIONS-1:0]   REGION_ACK   = '0,
  parameter logic [7:0]               TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [29:0]               address,
  input  logic                      read,
  input  logic                      write,
  output logic [31:0]               data_in,
  output logic [NUM_REGIONS-1:0]    cs,
  input  logic [32*NUM_REGIONS-1:0] slave_data,
  input  logic [NUM_REGIONS-1:0]    slave_ack,
  output logic                      ready,
  output logic                      bus_error
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [NUM_REGIONS-1:0] CS_BASE = NUM_REGIONS'(1);

  bus_state_t       state_q, state_d;
  logic [IDX_W-1:0] region_q;
  logic [CNT_W-1:0] count_q;
  logic [NUM_REGIONS-1:0] cs_q;
  logic             start_access;
  logic             request;
  logic [7:0]       tag;
  logic             match_hit;
  logic [IDX_W-1:0] match_index;
  logic             unused_addr;

  logic [3:0]  wait_tbl    [NUM_REGIONS];
  logic [31:0] slave_words [NUM_REGIONS];

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_unpack
    assign wait_tbl[g]    = REGION_WAITS[4*g +: 4];
    assign slave_words[g] = slave_data[32*g +: 32];
  end

  assign tag         = address[TAG_HI-WORD_SHIFT : TAG_LO-WORD_SHIFT];
  assign unused_addr = ^address[TAG_LO-WORD_SHIFT-1:0];
  assign request     = read | write;

  bus_fabric_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_TAGS (REGION_TAGS),
    .IDX_W       (IDX_W)
  ) u_match (
    .tag   (tag),
    .hit   (match_hit),
    .index (match_index)
  );

  // Next-state and ready decode; dropping both strobes mid-cycle is a silent abort.
  always_comb begin
    state_d      = state_q;
    ready        = 1'b0;
    start_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read && write) begin
          state_d = ST_ERROR;
        end else if (request) begin
          if (match_hit) begin
            state_d      = ST_ACCESS;
            start_access = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ACCESS: begin
        if (!request) begin
          state_d = ST_IDLE;
        end else if (REGION_ACK[region_q]) begin
          if (slave_ack[region_q]) begin
            ready   = 1'b1;
            state_d = ST_IDLE;
          end else if (count_q == TIMEOUT) begin
            state_d = ST_ERROR;
          end
        end else if (count_q == {4'h0, wait_tbl[region_q]}) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Chip select is registered so it stays glitch-free for the whole access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      region_q <= '0;
      count_q  <= '0;
      cs_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_access) begin
        region_q <= match_index;
        count_q  <= '0;
      end else if (state_q == ST_ACCESS) begin
        count_q <= sat_inc(count_q);
      end
      if (state_d != ST_ACCESS) begin
        cs_q <= '0;
      end else if (start_access) begin
        cs_q <= CS_BASE << match_index;
      end
    end
  end

  assign cs        = cs_q;
  assign bus_error = (state_q == ST_ERROR);
  assign data_in   = (state_q == ST_ACCESS) ? slave_words[region_q] : 32'h0;

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_bus_fabric;

  localparam logic [31:0] TAGS  = 32'hfffe_0100;
  localparam logic [15:0] WAITS = 16'h0530;
  localparam logic [3:0]  ACKM  = 4'b1000;
  localparam int          TMO   = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [29:0]  address;
  logic         read, write;
  logic [31:0]  data_in;
  logic [3:0]   cs;
  logic [127:0] slave_data;
  logic [3:0]   slave_ack;
  logic         ready, bus_error;

  int checks = 0;
  int errors = 0;

  // Region table restated from the intended memory map.
  int tag_of  [4] = '{8'h00, 8'h01, 8'hfe, 8'hff};
  int wait_of [4] = '{0, 3, 5, 0};
  bit ack_of  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Model: 0 idle, 1 in a slave access, 2 error pulse.
  int m_phase   = 0;
  int m_region  = 0;
  int m_elapsed = 0;

  logic [3:0]  exp_cs;
  logic [31:0] exp_data;
  logic        exp_ready, exp_err;

  bus_fabric #(
    .NUM_REGIONS  (4),
    .REGION_TAGS  (TAGS),
    .REGION_WAITS (WAITS),
    .REGION_ACK   (ACKM),
    .TIMEOUT      (8'(TMO))
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .read       (read),
    .write      (write),
    .data_in    (data_in),
    .cs         (cs),
    .slave_data (slave_data),
    .slave_ack  (slave_ack),
    .ready      (ready),
    .bus_error  (bus_error)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int lookup(input logic [29:0] word_addr);
    for (int i = 0; i < 4; i++)
      if (tag_of[i] == int'(word_addr[29:22])) return i;
    return -1;
  endfunction

  function automatic bit model_ready();
    if (m_phase != 1 || !(read || write)) return 1'b0;
    if (ack_of[m_region]) return slave_ack[m_region];
    return m_elapsed == wait_of[m_region];
  endfunction

  // Transaction-level model advanced on every clock edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase   <= 0;
      m_region  <= 0;
      m_elapsed <= 0;
    end else begin
      case (m_phase)
        2: m_phase <= 0;
        1: begin
          if (!(read || write)) m_phase <= 0;
          else if (model_ready()) m_phase <= 0;
          else if (ack_of[m_region] && m_elapsed >= TMO) m_phase <= 2;
          else m_elapsed <= m_elapsed + 1;
        end
        default: begin
          if (read && write) m_phase <= 2;
          else if (read || write) begin
            if (lookup(address) < 0) m_phase <= 2;
            else begin
              m_phase   <= 1;
              m_region  <= lookup(address);
              m_elapsed <= 0;
            end
          end
        end
      endcase
    end
  end

  // Compare process: outputs are sampled mid-cycle, away from the clock edge.
  always @(negedge clock) begin
    if (!reset) begin
      exp_cs    = 4'b0;
      exp_data  = 32'h0;
      exp_ready = 1'b0;
      exp_err   = (m_phase == 2);
      if (m_phase == 1) begin
        exp_cs    = 4'(1 << m_region);
        exp_data  = slave_data[32*m_region +: 32];
        exp_ready = model_ready();
      end
      check_value("model_cs", 32'(cs), 32'(exp_cs));
      check_value("model_ready", 32'(ready), 32'(exp_ready));
      check_value("model_bus_error", 32'(bus_error), 32'(exp_err));
      check_value("model_data_in", data_in, exp_data);
    end
  end

  task automatic run_request(input bit rd, input bit wr, input logic [31:0] byte_addr, input int ack_at,
                             output int cs_cycles, output int ready_at, output int err_at,
                             output logic [3:0] cs_seen, output logic [31:0] ready_data);
    bit done = 1'b0;
    cs_cycles  = 0;
    ready_at   = -1;
    err_at     = -1;
    cs_seen    = 4'b0;
    ready_data = 32'h0;
    address    = byte_addr[31:2];
    read       = rd;
    write      = wr;
    for (int k = 0; k < 40 && !done; k++) begin
      slave_ack = (k == ack_at) ? 4'b1000 : 4'b0000;
      @(negedge clock);
      if (cs != 4'b0) begin
        cs_cycles++;
        cs_seen |= cs;
      end
      if (ready) begin
        ready_at   = k;
        ready_data = data_in;
        done       = 1'b1;
      end
      if (bus_error) begin
        err_at = k;
        done   = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    read      = 1'b0;
    write     = 1'b0;
    slave_ack = 4'b0;
    check_value("cycle_completed", 32'(done), 32'd1);
    @(negedge clock);
    check_value("cs_released", 32'(cs), 32'd0);
    @(posedge clock);
    #1;
  endtask

  int          n_cs, r_at, e_at;
  logic [3:0]  seen;
  logic [31:0] rdata;

  initial begin
    reset      = 1'b1;
    address    = 30'h0;
    read       = 1'b0;
    write      = 1'b0;
    slave_ack  = 4'b0;
    slave_data = {32'hdddd_0003, 32'hcccc_0002, 32'hbbbb_0001, 32'haaaa_0000};
    #1;
    check_value("reset_cs", 32'(cs), 32'd0);
    check_value("reset_ready", 32'(ready), 32'd0);
    check_value("reset_bus_error", 32'(bus_error), 32'd0);
    check_value("reset_data_in", data_in, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] zero-wait read of region 0");
    run_request(1'b1, 1'b0, 32'h0000_0010, -1, n_cs, r_at, e_at, seen, rdata);
    check_value("t1_ready_cycle", 32'(r_at), 32'd1);
    check_value("t1_cs", 32'(seen), 32'h1);
    check_value("t1_data", rdata, 32'haaaa_0000);
    check_value("t1_cs_cycles", 32'(n_cs), 32'd1);

    $display("[TB] three-wait write of region 1");
    run_request(1'b0, 1'b1, 32'h0100_0000, -1, n_cs, r_at, e_at, seen, rdata);
    check_value("t2_cs", 32'(seen), 32'h2);
    check_value("t2_cs_cycles", 32'(n_cs), 32'd4);
    check_value("t2_ready_cycle", 32'(r_at), 32'd4);
    check_value("t2_no_error", 32'(e_at), 32'hffff_ffff);

    $display("[TB] unmapped read");
    run_request(1'b1, 1'b0, 32'h4200_0000, -1, n_cs, r_at, e_at, seen, rdata);
    check_value("t3_cs_cycles", 32'(n_cs), 32'd0);
    check_value("t3_error_cycle", 32'(e_at), 32'd1);
    check_value("t3_no_ready", 32'(r_at), 32'hffff_ffff);

    $display("[TB] ack region timeout");
    run_request(1'b1, 1'b0, 32'hff00_0000, -1, n_cs, r_at, e_at, seen, rdata);
    check_value("t4_cs", 32'(seen), 32'h8);
    check_value("t4_cs_cycles", 32'(n_cs), 32'd9);
    check_value("t4_error_cycle", 32'(e_at), 32'd10);
    check_value("t4_no_ready", 32'(r_at), 32'hffff_ffff);

    $display("[TB] ack region acknowledged on third access cycle");
    run_request(1'b1, 1'b0, 32'hff00_0000, 3, n_cs, r_at, e_at, seen, rdata);
    check_value("t5_ready_cycle", 32'(r_at), 32'd3);
    check_value("t5_cs_cycles", 32'(n_cs), 32'd3);
    check_value("t5_data", rdata, 32'hdddd_0003);

    $display("[TB] five-wait read of region 2 and read+write conflict");
    run_request(1'b1, 1'b0, 32'hfe12_3454, -1, n_cs, r_at, e_at, seen, rdata);
    check_value("t7_ready_cycle", 32'(r_at), 32'd6);
    check_value("t7_cs", 32'(seen), 32'h4);
    run_request(1'b1, 1'b1, 32'h0000_0000, -1, n_cs, r_at, e_at, seen, rdata);
    check_value("t8_error_cycle", 32'(e_at), 32'd1);
    check_value("t8_cs_cycles", 32'(n_cs), 32'd0);

    $display("[TB] reset during wait-state access");
    address = 30'(32'h0100_0000 >> 2);
    write   = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_value("t6_cs_before", 32'(cs), 32'h2);
    check_value("t6_data_before", data_in, 32'hbbbb_0001);
    #2;
    reset = 1'b1;
    write = 1'b0;
    #1;
    check_value("t6_cs", 32'(cs), 32'd0);
    check_value("t6_ready", 32'(ready), 32'd0);
    check_value("t6_bus_error", 32'(bus_error), 32'd0);
    check_value("t6_data_in", data_in, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    run_request(1'b1, 1'b0, 32'h0000_0040, -1, n_cs, r_at, e_at, seen, rdata);
    check_value("t6_restart_ready", 32'(r_at), 32'd1);

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int op  = $urandom_range(0, 9);
        int sel = $urandom_range(0, 4);
        read  = (op >= 2 && op <= 5) || op == 9;
        write = (op >= 6);
        if (sel < 4) address = {8'(tag_of[sel]), 22'($urandom)};
        else address = 30'($urandom);
      end
      slave_ack  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      slave_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clock);
      #1;
    end
    read      = 1'b0;
    write     = 1'b0;
    slave_ack = 4'b0;
    repeat (3) @(posedge clock);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
